// File: rtl/fifo_ctrl_1clk_fwft.sv
// First-word-fall-through FIFO controller around an external single-clock RAM with registered read data.
// A two-entry output buffer hides the one-cycle RAM read latency, so the FIFO keeps one word per cycle.
module fifo_ctrl_1clk_fwft #(
  parameter  int C_WIDTH = 32,
  parameter  int C_DEPTH = 1024,
  localparam int C_ADDR  = $clog2(C_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [C_WIDTH-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [C_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [C_ADDR+1:0]  count,
  output logic [C_ADDR-1:0]  ram_addra,
  output logic               ram_wea,
  output logic [C_WIDTH-1:0] ram_dina,
  output logic [C_ADDR-1:0]  ram_addrb,
  input  logic [C_WIDTH-1:0] ram_doutb
);

  localparam logic [C_ADDR:0] FULL_CNT = (C_ADDR+1)'(C_DEPTH);

  logic [C_ADDR:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, ram_cnt;
  logic               wr_ready_q, rd_issue_q;
  logic [1:0]         ocnt, ocnt_after_pop, ocnt_nxt;
  logic [C_WIDTH-1:0] obuf [2];
  logic               wr_en, pop, rd_issue;

  // NOTE: every signal gets a value on every pass, so no latch can be inferred.
  always_comb begin
    wr_en          = wr_valid & wr_ready_q;
    pop            = (ocnt != 2'd0) & rd_ready;
    ram_cnt        = wr_ptr - rd_ptr;
    ocnt_after_pop = ocnt - {1'b0, pop};
    // Issue only if the buffer still has room once the word already in flight lands.
    rd_issue       = (ram_cnt != '0) && ((ocnt_after_pop + {1'b0, rd_issue_q}) < 2'd2);
    wr_ptr_nxt     = wr_ptr + {{C_ADDR{1'b0}}, wr_en};
    rd_ptr_nxt     = rd_ptr + {{C_ADDR{1'b0}}, rd_issue};
    ocnt_nxt       = ocnt_after_pop + {1'b0, rd_issue_q};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_issue_q <= 1'b0;
      ocnt       <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      rd_issue_q <= rd_issue;
      ocnt       <= ocnt_nxt;
      wr_ready_q <= (wr_ptr_nxt - rd_ptr_nxt) != FULL_CNT;
    end
  end

  // NOTE: obuf holds data only and is qualified by ocnt, so it needs no reset.
  // With a pop and a capture into slot 0 together, the later capture wins.
  always_ff @(posedge clk) begin
    if (pop)        obuf[0] <= obuf[1];
    if (rd_issue_q) obuf[ocnt_after_pop[0]] <= ram_doutb;
  end

  assign wr_ready  = wr_ready_q;
  assign rd_valid  = (ocnt != 2'd0);
  assign rd_data   = obuf[0];
  assign count     = {1'b0, ram_cnt} + {{(C_ADDR+1){1'b0}}, rd_issue_q} + {{C_ADDR{1'b0}}, ocnt};
  assign ram_addra = wr_ptr[C_ADDR-1:0];
  assign ram_wea   = wr_en;
  assign ram_dina  = wr_data;
  assign ram_addrb = rd_ptr[C_ADDR-1:0];

  obuf_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_issue_q && (ocnt_after_pop == 2'd2)));

endmodule

// File: tb/tb_fifo_ctrl_1clk_fwft.sv
// Bench for fifo_ctrl_1clk_fwft: behavioural RAM, queue-based occupancy/visibility model checked every
// cycle, plus directed reset, latency, fill, streaming, random back-pressure and mid-traffic reset.
module tb_fifo_ctrl_1clk_fwft;
  localparam int C_WIDTH = 32;
  localparam int C_DEPTH = 16;
  localparam int AW      = $clog2(C_DEPTH);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [C_WIDTH-1:0] wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic [C_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               rd_ready;
  logic [AW+1:0]      count;
  logic [AW-1:0]      ram_addra;
  logic               ram_wea;
  logic [C_WIDTH-1:0] ram_dina;
  logic [AW-1:0]      ram_addrb;
  logic [C_WIDTH-1:0] ram_doutb;

  always #5 clk = ~clk;

  fifo_ctrl_1clk_fwft #(.C_WIDTH(C_WIDTH), .C_DEPTH(C_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // External RAM: synchronous write, registered read.
  logic [C_WIDTH-1:0] mem [C_DEPTH];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_doutb <= mem[ram_addrb];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a word accepted in cycle n (edges since reset) is at the head of RD_DATA from cycle n+3.
  typedef struct {
    logic [C_WIDTH-1:0] data;
    int                 tag;
  } entry_t;

  entry_t mq[$];
  int     since_rst = 0;
  int     wr_total  = 0;

  initial begin : model
    logic               wr_fire, pop_fire, exp_valid;
    logic [C_WIDTH-1:0] wd;
    forever begin
      @(negedge clk);
      wr_fire  = 1'b0;
      pop_fire = 1'b0;
      wd       = wr_data;
      if (!rst_n) begin
        mq.delete();
        since_rst = 0;
        wr_total  = 0;
        check("m_rst_count", count, 0);
        check("m_rst_rd_valid", rd_valid, 0);
        check("m_rst_wr_ready", wr_ready, 0);
        check("m_rst_wea", ram_wea, 0);
      end else begin
        exp_valid = (mq.size() > 0) && (since_rst >= mq[0].tag + 3);
        check("m_count", count, mq.size());
        check("m_rd_valid", rd_valid, exp_valid);
        if (exp_valid) check("m_rd_data", rd_data, mq[0].data);
        if (since_rst == 0)              check("m_wr_ready_first", wr_ready, 0);
        else if (mq.size() <= C_DEPTH)   check("m_wr_ready", wr_ready, 1);
        else if (mq.size() >= C_DEPTH+2) check("m_wr_ready_full", wr_ready, 0);
        check("m_wea", ram_wea, wr_valid && wr_ready);
        if (ram_wea) begin
          check("m_addra", ram_addra, wr_total % C_DEPTH);
          check("m_dina", ram_dina, wr_data);
        end
        wr_fire  = wr_valid && wr_ready;
        pop_fire = exp_valid && rd_ready;
      end
      @(posedge clk);
      if (rst_n) begin
        if (pop_fire) void'(mq.pop_front());
        if (wr_fire) begin
          mq.push_back('{data: wd, tag: since_rst});
          wr_total++;
        end
        since_rst++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc, n;
    logic seen_valid;
    for (int i = 0; i < C_DEPTH; i++) mem[i] = '0;
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Reset held with a pending write.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_wea", ram_wea, 0);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    step();
    check("rst_ready_after_release", wr_ready, 1);

    // Latency into an empty FIFO.
    wr_data  = 32'hA5A5_0001;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    check("lat_t0", rd_valid, 0);
    step();
    check("lat_t1", rd_valid, 0);
    step();
    check("lat_valid", rd_valid, 1);
    check("lat_data", rd_data, 32'hA5A5_0001);
    check("lat_count", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("lat_pop_count", count, 0);

    // Fill to capacity, then drain in order.
    acc = 0;
    for (int i = 0; i < C_DEPTH + 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = acc + 1;
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    check("fill_accepts", acc, C_DEPTH + 2);
    check("fill_count", count, C_DEPTH + 2);
    check("fill_wr_ready", wr_ready, 0);
    n = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 4*C_DEPTH && count != 0; i++) begin
      if (rd_valid) begin
        check("fill_order", rd_data, n + 1);
        n++;
      end
      step();
    end
    rd_ready = 1'b0;
    check("fill_popped", n, C_DEPTH + 2);

    // Streaming: write and pop every cycle across several pointer wraps.
    acc = 0;
    n = 0;
    seen_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3*C_DEPTH + 10 && n < 3*C_DEPTH; i++) begin
      wr_valid = (acc < 3*C_DEPTH);
      wr_data  = 32'h1000 + acc;
      if (wr_valid && wr_ready) acc++;
      if (seen_valid) check("stream_no_bubble", rd_valid, 1);
      if (rd_valid) begin
        check("stream_order", rd_data, 32'h1000 + n);
        n++;
        seen_valid = 1'b1;
      end
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check("stream_total", n, 3*C_DEPTH);

    // Random back-pressure, then a read-heavy phase so the FIFO also runs dry.
    for (int i = 0; i < 10000; i++) begin
      wr_valid = ($urandom_range(99) < 70);
      wr_data  = $urandom();
      rd_ready = ($urandom_range(99) < 50);
      step();
    end
    for (int i = 0; i < 1000; i++) begin
      wr_valid = ($urandom_range(99) < 30);
      wr_data  = $urandom();
      rd_ready = ($urandom_range(99) < 70);
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 4*C_DEPTH && count != 0; i++) step();
    rd_ready = 1'b0;
    check("drain_empty", count, 0);

    // Mid-operation reset with five words held.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h5000 + i;
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();
    check("mid_count5", count, 5);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_wea", ram_wea, 0);
    step();
    step();
    wr_data = 32'h1234;
    rst_n   = 1'b1;
    for (int i = 0; i < 10 && !wr_ready; i++) step();
    check("mid_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 10 && !rd_valid; i++) step();
    check("mid_first_valid", rd_valid, 1);
    check("mid_first_word", rd_data, 32'h1234);
    check("mid_first_count", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
